// File: rtl/pcs_gray_pkg.sv
// Gray-pointer helpers shared by the read- and write-side FIFO pointer logic.
package pcs_gray_pkg;

  localparam int unsigned PTR_W_DEF       = 5;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef logic [PTR_W_DEF-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // MSB passes through; each lower bit is the XOR of all Gray bits above and including it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W_DEF-1] = g[PTR_W_DEF-1];
    for (int i = int'(PTR_W_DEF) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pcs_sync_vec.sv
// Multi-stage flop chain for a Gray-coded vector crossing into this clock domain.
module pcs_sync_vec #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the incoming vector through the synchronizer stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(STAGES); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/graycounter_32_rdside.sv
// Read-side pointer of the 16-entry Gray-pointer async FIFO: syncs and decodes the write
// pointer, derives level/empty, advances the read pointer and returns it Gray-coded.
module graycounter_32_rdside
  import pcs_gray_pkg::*;
#(
  parameter int unsigned PTR_W       = PTR_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PTR_W-1:0] wr_gray,
  input  logic             rd_en,
  output logic             rd_ack,
  output logic [PTR_W-2:0] rd_addr,
  output logic [PTR_W-1:0] rd_gray,
  output logic             empty,
  output logic [PTR_W-1:0] level,
  output logic             underflow,
  output logic             gray_err,
  output logic             level_err
);

  localparam int unsigned Depth = 2 ** (PTR_W - 1);

  logic [PTR_W-1:0] w_wr_gray_sync;
  logic [PTR_W-1:0] r_wr_bin;
  logic [PTR_W-1:0] r_rd_bin;
  logic [PTR_W-1:0] r_rd_gray;
  logic [PTR_W-1:0] w_rd_bin_nxt;
  logic [PTR_W-1:0] w_level;
  logic [PTR_W-1:0] w_gray_diff;
  logic             w_empty;
  logic             w_ack;
  logic             w_gray_multi;
  logic             w_level_over;
  logic             r_gray_err;
  logic             r_level_err;

  pcs_sync_vec #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (wr_gray),
    .o_q   (w_wr_gray_sync)
  );

  // Modulo subtraction keeps level correct when either pointer wraps.
  assign w_level      = r_wr_bin - r_rd_bin;
  assign w_empty      = (w_level == '0);
  assign w_ack        = rd_en & ~w_empty;
  assign w_rd_bin_nxt = r_rd_bin + PTR_W'(1);

  // r_wr_bin holds the decode of the previous sync output, so re-encoding it gives the
  // last-stage value from one cycle ago. x & (x-1) != 0 means more than one bit changed.
  assign w_gray_diff  = w_wr_gray_sync ^ bin2gray(r_wr_bin);
  assign w_gray_multi = (w_gray_diff & (w_gray_diff - PTR_W'(1))) != '0;
  assign w_level_over = w_level > PTR_W'(Depth);

  // Register the binary decode of the synchronized write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_bin <= '0;
    end else begin
      r_wr_bin <= gray2bin(w_wr_gray_sync);
    end
  end

  // Advance the read pointer and its Gray copy together on each accepted pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_bin  <= '0;
      r_rd_gray <= '0;
    end else if (w_ack) begin
      r_rd_bin  <= w_rd_bin_nxt;
      r_rd_gray <= bin2gray(w_rd_bin_nxt);
    end
  end

  // Sticky error flags; they report but never stall the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gray_err  <= 1'b0;
      r_level_err <= 1'b0;
    end else begin
      if (w_gray_multi) r_gray_err  <= 1'b1;
      if (w_level_over) r_level_err <= 1'b1;
    end
  end

  assign rd_ack    = w_ack;
  assign rd_addr   = r_rd_bin[PTR_W-2:0];
  assign rd_gray   = r_rd_gray;
  assign empty     = w_empty;
  assign level     = w_level;
  assign underflow = rd_en & w_empty;
  assign gray_err  = r_gray_err;
  assign level_err = r_level_err;

endmodule

// File: tb/tb_graycounter_32_rdside.sv
module tb_graycounter_32_rdside;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] wr_gray;
  logic       rd_en;
  logic       rd_ack;
  logic [3:0] rd_addr;
  logic [4:0] rd_gray;
  logic       empty;
  logic [4:0] level;
  logic       underflow;
  logic       gray_err;
  logic       level_err;

  int checks   = 0;
  int failures = 0;

  graycounter_32_rdside dut (
    .clk       (clk),
    .reset     (reset),
    .wr_gray   (wr_gray),
    .rd_en     (rd_en),
    .rd_ack    (rd_ack),
    .rd_addr   (rd_addr),
    .rd_gray   (rd_gray),
    .empty     (empty),
    .level     (level),
    .underflow (underflow),
    .gray_err  (gray_err),
    .level_err (level_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // Reference model state
  logic [4:0] m_s0, m_s1, m_prev, m_wrbin, m_rdbin, m_rdgray;
  logic       m_gerr, m_lerr;
  logic [4:0] m_wg;
  logic       m_re;

  typedef struct {
    int lvl; int emp; int ack; int ufl; int addr; int rgray; int gerr; int lerr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0] wg; logic re;
    int lvl; int emp; int ack; int ufl; int rgray;
  } vec_t;

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] gv);
    logic [4:0] b;
    b[4] = gv[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ gv[i];
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_s0 = '0; m_s1 = '0; m_prev = '0; m_wrbin = '0; m_rdbin = '0; m_rdgray = '0;
    m_gerr = 1'b0; m_lerr = 1'b0;
  endtask

  // Drive inputs, push model expectation, then pop and compare once outputs settle.
  task automatic drive_check(input logic [4:0] wg, input logic re);
    exp_t e;
    logic [4:0] lv;
    wr_gray = wg; rd_en = re; m_wg = wg; m_re = re;
    lv = m_wrbin - m_rdbin;
    e.lvl = int'(lv); e.emp = int'(lv == 0); e.ack = int'(re && lv != 0);
    e.ufl = int'(re && lv == 0); e.addr = int'(m_rdbin[3:0]); e.rgray = int'(m_rdgray);
    e.gerr = int'(m_gerr); e.lerr = int'(m_lerr);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("sb_level", int'(level), e.lvl);
    chk("sb_empty", int'(empty), e.emp);
    chk("sb_rd_ack", int'(rd_ack), e.ack);
    chk("sb_underflow", int'(underflow), e.ufl);
    chk("sb_rd_addr", int'(rd_addr), e.addr);
    chk("sb_rd_gray", int'(rd_gray), e.rgray);
    chk("sb_gray_err", int'(gray_err), e.gerr);
    chk("sb_level_err", int'(level_err), e.lerr);
  endtask

  task automatic advance();
    logic [4:0] lv;
    @(posedge clk);
    lv = m_wrbin - m_rdbin;
    if ($countones(m_s1 ^ m_prev) > 1) m_gerr = 1'b1;
    if (lv > 5'd16) m_lerr = 1'b1;
    if (m_re && lv != 0) begin
      m_rdbin  = m_rdbin + 5'd1;
      m_rdgray = g(m_rdbin);
    end
    m_wrbin = g2b(m_s1);
    m_prev  = m_s1;
    m_s1    = m_s0;
    m_s0    = m_wg;
    @(negedge clk);
  endtask

  task automatic step(input logic [4:0] wg, input logic re);
    drive_check(wg, re);
    advance();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset();
    rd_en = 1'b0; wr_gray = 5'd0;
    #2 reset = 1'b1;
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_rd_ack", int'(rd_ack), 0);
    chk("rst_underflow", int'(underflow), 0);
    chk("rst_rd_gray", int'(rd_gray), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_gray_err", int'(gray_err), 0);
    chk("rst_level_err", int'(level_err), 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{5'b00000, 1'b0, 0, 1, 0, 0, 5'b00000};
    vecs[1] = '{5'b00001, 1'b0, 0, 1, 0, 0, 5'b00000};
    vecs[2] = '{5'b00011, 1'b0, 0, 1, 0, 0, 5'b00000};
    vecs[3] = '{5'b00011, 1'b0, 0, 1, 0, 0, 5'b00000};
    vecs[4] = '{5'b00011, 1'b0, 1, 0, 0, 0, 5'b00000};
    vecs[5] = '{5'b00011, 1'b1, 2, 0, 1, 0, 5'b00000};
    vecs[6] = '{5'b00011, 1'b1, 1, 0, 1, 0, 5'b00001};
    vecs[7] = '{5'b00011, 1'b1, 0, 1, 0, 1, 5'b00011};
    vecs[8] = '{5'b00011, 1'b0, 0, 1, 0, 0, 5'b00011};

    reset = 1'b1; wr_gray = 5'd0; rd_en = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state, sync latency, pops and underflow
    for (int i = 0; i < 9; i++) begin
      drive_check(vecs[i].wg, vecs[i].re);
      chk($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
      chk($sformatf("vec%0d_empty", i), int'(empty), vecs[i].emp);
      chk($sformatf("vec%0d_rd_ack", i), int'(rd_ack), vecs[i].ack);
      chk($sformatf("vec%0d_underflow", i), int'(underflow), vecs[i].ufl);
      chk($sformatf("vec%0d_rd_gray", i), int'(rd_gray), vecs[i].rgray);
      chk($sformatf("vec%0d_flags", i), int'({gray_err, level_err}), 0);
      advance();
    end

    // Walk both pointers up to 30 with concurrent writes and pops
    for (int b = 3; b <= 30; b++) step(g(5'(b)), 1'b1);
    for (int i = 0; i < 6; i++) step(g(5'd30), 1'b1);
    chk("pre_wrap_rd_gray", int'(rd_gray), 5'b10001);
    chk("pre_wrap_level", int'(level), 0);

    // Writer wraps 30 -> 31 -> 0 -> 1, leaving three entries across the wrap
    step(g(5'd31), 1'b0);
    step(g(5'd0), 1'b0);
    step(g(5'd1), 1'b0);
    for (int i = 0; i < 3; i++) step(g(5'd1), 1'b0);
    chk("wrap_level", int'(level), 3);
    step(g(5'd1), 1'b1);
    chk("wrap_rd_gray_31", int'(rd_gray), 5'b10000);
    chk("wrap_rd_addr_31", int'(rd_addr), 15);
    step(g(5'd1), 1'b1);
    chk("wrap_rd_gray_0", int'(rd_gray), 5'b00000);
    chk("wrap_rd_addr_0", int'(rd_addr), 0);
    chk("wrap_level_after", int'(level), 1);
    chk("wrap_no_gray_err", int'(gray_err), 0);

    // Build level 5 then reset mid-stream and resume from zero
    for (int b = 2; b <= 5; b++) step(g(5'(b)), 1'b0);
    for (int i = 0; i < 3; i++) step(g(5'd5), 1'b0);
    chk("mid_level5", int'(level), 5);
    mid_reset();
    for (int i = 0; i < 3; i++) step(5'b00001, 1'b1);
    chk("resume_level1", int'(level), 1);
    step(5'b00001, 1'b1);
    chk("resume_rd_gray", int'(rd_gray), 5'b00001);

    // Two-bit jump on the write pointer sets a sticky gray_err; popping continues
    mid_reset();
    for (int i = 0; i < 5; i++) step(5'b00011, 1'b0);
    chk("gerr_set", int'(gray_err), 1);
    chk("gerr_level", int'(level), 2);
    for (int i = 0; i < 3; i++) step(5'b00011, 1'b1);
    chk("gerr_sticky", int'(gray_err), 1);
    chk("gerr_popped", int'(rd_gray), 5'b00011);

    // Overrun: write pointer jumps to 20 entries ahead
    mid_reset();
    for (int i = 0; i < 5; i++) step(g(5'd20), 1'b0);
    chk("lerr_level", int'(level), 20);
    chk("lerr_set", int'(level_err), 1);
    step(g(5'd20), 1'b1);
    chk("lerr_sticky", int'(level_err), 1);
    mid_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
